// File: rtl/image_dram_pkg.sv
`default_nettype none
//----------------------------------------------------------------------
// Module : image_dram_pkg
// Brief  : shared FSM type and AXI constants for the image DRAM reader
// Rev    : 1.0  initial release
//----------------------------------------------------------------------
package image_dram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } dram_rd_state_e;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned AXI_4K_BYTES   = 4096;

endpackage
`default_nettype wire

// File: rtl/image_dram_burst_calc.sv
`default_nettype none
//----------------------------------------------------------------------
// Module : image_dram_burst_calc
// Brief  : beats in the next burst, limited by request remainder and 4 KiB page
// Rev    : 1.0  initial release
//----------------------------------------------------------------------
module image_dram_burst_calc
  import image_dram_pkg::*;
#(
  parameter int BPB_LOG2 = 4
) (
  input  logic [11:0] cur_ofs,
  input  logic [7:0]  remaining,
  output logic [7:0]  burst_beats
);

  logic [12:0] w_bytes_to_4k;
  logic [12:0] w_beats_to_4k;

  // cur_ofs is beat aligned, so the shift is exact
  assign w_bytes_to_4k = 13'(AXI_4K_BYTES) - {1'b0, cur_ofs};
  assign w_beats_to_4k = w_bytes_to_4k >> BPB_LOG2;
  assign burst_beats   = ({5'b0, remaining} < w_beats_to_4k) ? remaining : w_beats_to_4k[7:0];

endmodule
`default_nettype wire

// File: rtl/image_dram_reader.sv
`default_nettype none
//----------------------------------------------------------------------
// Module : image_dram_reader
// Brief  : AXI4 read master; splits requests into INCR bursts at 4 KiB pages.
//          Define DRAM_READER_PERF_EN to add burst/latency perf counters.
// Rev    : 1.0  initial release
//----------------------------------------------------------------------
module image_dram_reader
  import image_dram_pkg::*;
#(
  parameter int         DRAM_ADDR_WIDTH = 39,
  parameter int         DRAM_DATA_WIDTH = 128,
  parameter int         AXI_ID_WIDTH    = 1,
  parameter logic [3:0] AXI_ARCACHE     = 4'b0011
) (
  input  logic                       clk_pixel,
  input  logic                       dram_reader_reset,
  input  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
  input  logic [7:0]                 dram_read_len,
  input  logic                       dram_read_en,
  output logic                       dram_read_busy,
  output logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
  output logic                       dram_read_data_valid,
  output logic                       dram_read_error,
`ifdef DRAM_READER_PERF_EN
  output logic [31:0]                perf_burst_count,
  output logic [15:0]                perf_max_latency,
`endif
  output logic [DRAM_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic [3:0]                 m_axi_arcache,
  output logic [2:0]                 m_axi_arprot,
  output logic [AXI_ID_WIDTH-1:0]    m_axi_arid,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  input  logic [DRAM_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic [AXI_ID_WIDTH-1:0]    m_axi_rid,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready
);

  localparam int c_BPB_LOG2 = $clog2(DRAM_DATA_WIDTH / 8);
  localparam logic [DRAM_ADDR_WIDTH-1:0] c_ALIGN_MASK =
    DRAM_ADDR_WIDTH'((64'd1 << c_BPB_LOG2) - 64'd1);

  dram_rd_state_e             r_state;
  logic [DRAM_ADDR_WIDTH-1:0] r_cur_addr;
  logic [7:0]                 r_remaining;
  logic [7:0]                 r_burst_beats;
  logic [8:0]                 r_beat_cnt;
  logic                       r_arvalid;
  logic                       r_rready;
  logic [DRAM_DATA_WIDTH-1:0] r_data;
  logic                       r_data_valid;
  logic                       r_error;

  logic [7:0] w_burst_beats;
  logic       w_ar_hs;
  logic       w_beat_is_last;
  logic       w_unused;

  image_dram_burst_calc #(
    .BPB_LOG2 (c_BPB_LOG2)
  ) u_burst_calc (
    .cur_ofs     (r_cur_addr[11:0]),
    .remaining   (r_remaining),
    .burst_beats (w_burst_beats)
  );

  assign w_ar_hs        = r_arvalid & m_axi_arready;
  assign w_beat_is_last = ((r_beat_cnt + 9'd1) == {1'b0, r_burst_beats});
  assign w_unused       = ^m_axi_rid;

  always_ff @(posedge clk_pixel) begin
    if (dram_reader_reset) begin
      r_state       <= IDLE;
      r_cur_addr    <= '0;
      r_remaining   <= '0;
      r_burst_beats <= '0;
      r_beat_cnt    <= '0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_data        <= '0;
      r_data_valid  <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      if (dram_read_en && (r_state != IDLE))
        r_error <= 1'b1;
      case (r_state)
        IDLE: begin
          if (dram_read_en && (dram_read_len != 8'd0)) begin
            r_cur_addr  <= dram_read_addr & ~c_ALIGN_MASK;
            r_remaining <= dram_read_len;
            r_arvalid   <= 1'b1;
            r_state     <= ADDR;
          end
        end
        ADDR: begin
          if (w_ar_hs) begin
            r_burst_beats <= w_burst_beats;
            r_beat_cnt    <= '0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b1;
            r_state       <= DATA;
          end
        end
        DATA: begin
          if (m_axi_rvalid) begin
            r_data       <= m_axi_rdata;
            r_data_valid <= 1'b1;
            r_beat_cnt   <= r_beat_cnt + 9'd1;
            if ((m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rlast != w_beat_is_last))
              r_error <= 1'b1;
            // The slave's rlast closes the burst even if it disagrees with arlen
            if (m_axi_rlast) begin
              r_cur_addr  <= r_cur_addr + (DRAM_ADDR_WIDTH'(r_burst_beats) << c_BPB_LOG2);
              r_remaining <= r_remaining - r_burst_beats;
              r_rready    <= 1'b0;
              if (r_remaining != r_burst_beats) begin
                r_arvalid <= 1'b1;
                r_state   <= ADDR;
              end else begin
                r_state <= IDLE;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef DRAM_READER_PERF_EN
  logic [31:0] r_burst_count;
  logic [15:0] r_max_lat;
  logic [15:0] r_lat_cnt;
  logic        r_lat_armed;

  // r_lat_cnt counts edges since the AR handshake until the first R beat
  always_ff @(posedge clk_pixel) begin
    if (dram_reader_reset) begin
      r_burst_count <= '0;
      r_max_lat     <= '0;
      r_lat_cnt     <= '0;
      r_lat_armed   <= 1'b0;
    end else if (w_ar_hs) begin
      r_burst_count <= r_burst_count + 32'd1;
      r_lat_cnt     <= 16'd1;
      r_lat_armed   <= 1'b1;
    end else if (r_lat_armed) begin
      if ((r_state == DATA) && m_axi_rvalid) begin
        r_lat_armed <= 1'b0;
        if (r_lat_cnt > r_max_lat)
          r_max_lat <= r_lat_cnt;
      end else if (r_lat_cnt != 16'hFFFF) begin
        r_lat_cnt <= r_lat_cnt + 16'd1;
      end
    end
  end

  assign perf_burst_count = r_burst_count;
  assign perf_max_latency = r_max_lat;
`endif

  assign dram_read_busy       = (r_state != IDLE) | dram_read_en;
  assign dram_read_data       = r_data;
  assign dram_read_data_valid = r_data_valid;
  assign dram_read_error      = r_error;

  assign m_axi_araddr  = r_cur_addr;
  assign m_axi_arlen   = w_burst_beats - 8'd1;
  assign m_axi_arsize  = 3'(c_BPB_LOG2);
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arcache = AXI_ARCACHE;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arid    = '0;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_image_dram_reader.sv
`default_nettype none
//----------------------------------------------------------------------
// Module : tb_image_dram_reader
// Brief  : randomized bench with AXI slave model and burst-splitting reference
// Rev    : 1.0  initial release
//----------------------------------------------------------------------
module tb_image_dram_reader;

  localparam int AW  = 39;
  localparam int DW  = 128;
  localparam int BPB = DW / 8;

  logic          clk_pixel = 1'b0;
  logic          dram_reader_reset;
  logic [AW-1:0] dram_read_addr;
  logic [7:0]    dram_read_len;
  logic          dram_read_en;
  logic          dram_read_busy;
  logic [DW-1:0] dram_read_data;
  logic          dram_read_data_valid;
  logic          dram_read_error;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic [3:0]    m_axi_arcache;
  logic [2:0]    m_axi_arprot;
  logic [0:0]    m_axi_arid;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast;
  logic [0:0]    m_axi_rid;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
`ifdef DRAM_READER_PERF_EN
  logic [31:0]   perf_burst_count;
  logic [15:0]   perf_max_latency;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // slave configuration and logs
  int  ar_stall = 0;
  int  r_delay  = 1;
  bit  gap_en   = 1'b0;
  int  bad_beat = -1;
  int  beat_idx = 0;
  bit  ar_unstable = 1'b0;
  logic [AW-1:0] ar_addr_q[$];
  int            ar_len_q[$];
  logic [DW-1:0] exp_data[$];
  int            exp_cyc[$];
  logic [DW-1:0] got_data[$];
  int            got_cyc[$];
  logic [AW-1:0] mdl_addr[$];
  int            mdl_len[$];

  always #5 clk_pixel = ~clk_pixel;
  always @(posedge clk_pixel) cyc <= cyc + 1;

  image_dram_reader dut (
    .clk_pixel            (clk_pixel),
    .dram_reader_reset    (dram_reader_reset),
    .dram_read_addr       (dram_read_addr),
    .dram_read_len        (dram_read_len),
    .dram_read_en         (dram_read_en),
    .dram_read_busy       (dram_read_busy),
    .dram_read_data       (dram_read_data),
    .dram_read_data_valid (dram_read_data_valid),
    .dram_read_error      (dram_read_error),
`ifdef DRAM_READER_PERF_EN
    .perf_burst_count     (perf_burst_count),
    .perf_max_latency     (perf_max_latency),
`endif
    .m_axi_araddr         (m_axi_araddr),
    .m_axi_arlen          (m_axi_arlen),
    .m_axi_arsize         (m_axi_arsize),
    .m_axi_arburst        (m_axi_arburst),
    .m_axi_arcache        (m_axi_arcache),
    .m_axi_arprot         (m_axi_arprot),
    .m_axi_arid           (m_axi_arid),
    .m_axi_arvalid        (m_axi_arvalid),
    .m_axi_arready        (m_axi_arready),
    .m_axi_rdata          (m_axi_rdata),
    .m_axi_rresp          (m_axi_rresp),
    .m_axi_rlast          (m_axi_rlast),
    .m_axi_rid            (m_axi_rid),
    .m_axi_rvalid         (m_axi_rvalid),
    .m_axi_rready         (m_axi_rready)
  );

  // AXI slave: accepts one AR, returns arlen+1 random beats
  initial begin : slave
    logic [AW-1:0] a0;
    int            l0;
    bit            ok;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    m_axi_rlast   = 1'b0;
    m_axi_rid     = '0;
    forever begin
      @(posedge clk_pixel); #1;
      if (m_axi_arvalid === 1'b1 && dram_reader_reset === 1'b0) begin
        a0 = m_axi_araddr;
        l0 = int'(m_axi_arlen);
        for (int i = 0; i < ar_stall; i++) begin
          @(posedge clk_pixel); #1;
          if (m_axi_araddr !== a0 || int'(m_axi_arlen) != l0 || m_axi_arvalid !== 1'b1 ||
              dram_read_busy !== 1'b1)
            ar_unstable = 1'b1;
        end
        m_axi_arready = 1'b1;
        @(posedge clk_pixel); #1;
        m_axi_arready = 1'b0;
        if (dram_reader_reset === 1'b0) begin
          ar_addr_q.push_back(a0);
          ar_len_q.push_back(l0);
          repeat (r_delay - 1) begin @(posedge clk_pixel); #1; end
          for (int b = 0; b <= l0; b++) begin
            if (gap_en)
              while ($urandom_range(0, 2) == 0) begin @(posedge clk_pixel); #1; end
            if (dram_reader_reset === 1'b1) break;
            m_axi_rdata  = {$urandom, $urandom, $urandom, $urandom};
            m_axi_rresp  = (beat_idx == bad_beat) ? 2'b10 : 2'b00;
            m_axi_rlast  = (b == l0);
            m_axi_rvalid = 1'b1;
            ok = (m_axi_rready === 1'b1);
            @(posedge clk_pixel); #1;
            m_axi_rvalid = 1'b0;
            m_axi_rlast  = 1'b0;
            m_axi_rresp  = 2'b00;
            if (ok) begin
              exp_data.push_back(m_axi_rdata);
              exp_cyc.push_back(cyc);
              beat_idx++;
            end
          end
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(posedge clk_pixel); #1;
      if (dram_read_data_valid === 1'b1) begin
        got_data.push_back(dram_read_data);
        got_cyc.push_back(cyc);
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  // reference: walk the request, cutting at each 4 KiB page
  function automatic void model_bursts(input logic [AW-1:0] addr, input int len);
    logic [AW-1:0] a;
    int rem, n, room;
    mdl_addr.delete();
    mdl_len.delete();
    a   = addr - (addr % BPB);
    rem = len;
    while (rem > 0) begin
      room = (4096 - int'(a % 4096)) / BPB;
      n    = (rem < room) ? rem : room;
      mdl_addr.push_back(a);
      mdl_len.push_back(n - 1);
      a   = a + AW'(n * BPB);
      rem = rem - n;
    end
  endfunction

  task automatic apply_reset();
    dram_reader_reset = 1'b1;
    dram_read_en      = 1'b0;
    repeat (3) @(posedge clk_pixel);
    #1;
    dram_reader_reset = 1'b0;
    ar_addr_q.delete(); ar_len_q.delete();
    exp_data.delete();  exp_cyc.delete();
    got_data.delete();  got_cyc.delete();
    beat_idx = 0;
    ar_unstable = 1'b0;
  endtask

  task automatic strobe(input logic [AW-1:0] addr, input int len);
    dram_read_addr = addr;
    dram_read_len  = len[7:0];
    dram_read_en   = 1'b1;
    #1;
  endtask

  task automatic end_strobe();
    @(posedge clk_pixel); #1;
    dram_read_en = 1'b0;
  endtask

  task automatic wait_idle(output int low_cyc, output bit timed_out);
    timed_out = 1'b1;
    low_cyc   = -1;
    for (int i = 0; i < 5000; i++) begin
      if (dram_read_busy === 1'b0) begin
        timed_out = 1'b0;
        low_cyc   = cyc;
        break;
      end
      @(posedge clk_pixel); #1;
    end
    @(posedge clk_pixel); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++; if (m_axi_arvalid !== 1'b0) begin miscompares++; $display("FAIL reset_arvalid: got %b want 0", m_axi_arvalid); end
    vectors++; if (m_axi_rready !== 1'b0) begin miscompares++; $display("FAIL reset_rready: got %b want 0", m_axi_rready); end
    vectors++; if (dram_read_data !== '0) begin miscompares++; $display("FAIL reset_data: got %h want 0", dram_read_data); end
    vectors++; if (dram_read_data_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", dram_read_data_valid); end
    vectors++; if (dram_read_error !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b want 0", dram_read_error); end
    vectors++; if (dram_read_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", dram_read_busy); end
    vectors++;
    if (m_axi_arsize !== 3'd4 || m_axi_arburst !== 2'b01 || m_axi_arcache !== 4'b0011 ||
        m_axi_arprot !== 3'b000 || m_axi_arid !== 1'b0) begin
      miscompares++;
      $display("FAIL ar_consts: got size=%0d burst=%b cache=%b prot=%b id=%b want 4 01 0011 000 0",
               m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arprot, m_axi_arid);
    end
`ifdef DRAM_READER_PERF_EN
    vectors++; if (perf_burst_count !== 32'd0 || perf_max_latency !== 16'd0) begin miscompares++; $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_burst_count, perf_max_latency); end
`endif
  endtask

  task automatic test_transfer(input logic [AW-1:0] addr, input int len, input int delay, input bit gaps);
    int low_cyc;
    bit to;
    apply_reset();
    r_delay  = delay;
    gap_en   = gaps;
    ar_stall = gaps ? $urandom_range(0, 3) : 0;
    model_bursts(addr, len);
    strobe(addr, len);
    vectors++; if (dram_read_busy !== 1'b1) begin miscompares++; $display("FAIL busy_strobe: got %b want 1", dram_read_busy); end
    end_strobe();
    wait_idle(low_cyc, to);
    vectors++; if (to) begin miscompares++; $display("FAIL idle_timeout: got busy want idle (addr %h len %0d)", addr, len); end
    vectors++;
    if (ar_addr_q.size() != mdl_addr.size()) begin
      miscompares++;
      $display("FAIL ar_count: got %0d want %0d (addr %h len %0d)", ar_addr_q.size(), mdl_addr.size(), addr, len);
    end else begin
      foreach (mdl_addr[i]) begin
        vectors++;
        if (ar_addr_q[i] !== mdl_addr[i] || ar_len_q[i] != mdl_len[i]) begin
          miscompares++;
          $display("FAIL ar[%0d]: got addr %h len %0d want addr %h len %0d", i, ar_addr_q[i], ar_len_q[i], mdl_addr[i], mdl_len[i]);
        end
      end
    end
    vectors++;
    if (got_data.size() != len || exp_data.size() != len) begin
      miscompares++;
      $display("FAIL beat_count: got %0d sent %0d want %0d", got_data.size(), exp_data.size(), len);
    end else begin
      foreach (exp_data[i]) begin
        vectors++;
        if (got_data[i] !== exp_data[i] || got_cyc[i] != exp_cyc[i]) begin
          miscompares++;
          $display("FAIL beat[%0d]: got %h @%0d want %h @%0d", i, got_data[i], got_cyc[i], exp_data[i], exp_cyc[i]);
        end
      end
      vectors++;
      if (low_cyc != exp_cyc[exp_cyc.size()-1]) begin
        miscompares++;
        $display("FAIL busy_drop: got cycle %0d want %0d", low_cyc, exp_cyc[exp_cyc.size()-1]);
      end
    end
    vectors++; if (dram_read_error !== 1'b0) begin miscompares++; $display("FAIL clean_error: got %b want 0", dram_read_error); end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int k = 0; k < 8; k++) begin
      a = AW'({$urandom, $urandom});
      if (k[0]) a[11:0] = 12'(4096 - BPB * $urandom_range(1, 20));
      test_transfer(a, $urandom_range(1, 255), $urandom_range(1, 4), 1'b1);
    end
  endtask

  task automatic test_ar_stall();
    int low_cyc;
    bit to;
    apply_reset();
    ar_stall = 20; r_delay = 1; gap_en = 1'b0;
    strobe(39'h3000, 16);
    end_strobe();
    wait_idle(low_cyc, to);
    vectors++; if (to) begin miscompares++; $display("FAIL stall_timeout: got busy want idle"); end
    vectors++; if (ar_unstable) begin miscompares++; $display("FAIL stall_stable: got changing AR/busy want stable"); end
    vectors++; if (ar_addr_q.size() != 1) begin miscompares++; $display("FAIL stall_ar_count: got %0d want 1", ar_addr_q.size()); end
    vectors++; if (got_data.size() != 16) begin miscompares++; $display("FAIL stall_beats: got %0d want 16", got_data.size()); end
    ar_stall = 0;
  endtask

  task automatic test_error();
    int low_cyc;
    bit to;
    // bad response only
    apply_reset();
    r_delay = 1; gap_en = 1'b0; bad_beat = 5;
    strobe(39'h1000, 32);
    end_strobe();
    wait_idle(low_cyc, to);
    bad_beat = -1;
    vectors++; if (dram_read_error !== 1'b1) begin miscompares++; $display("FAIL rresp_error: got %b want 1", dram_read_error); end
    vectors++;
    if (got_data.size() != 32 || exp_data.size() != 32) begin
      miscompares++;
      $display("FAIL rresp_beats: got %0d want 32", got_data.size());
    end else begin
      foreach (exp_data[i]) begin
        vectors++;
        if (got_data[i] !== exp_data[i]) begin miscompares++; $display("FAIL rresp_beat[%0d]: got %h want %h", i, got_data[i], exp_data[i]); end
      end
    end
    repeat (20) @(posedge clk_pixel);
    #1;
    vectors++; if (dram_read_error !== 1'b1) begin miscompares++; $display("FAIL error_sticky: got %b want 1", dram_read_error); end
    // dropped request only
    apply_reset();
    vectors++; if (dram_read_error !== 1'b0) begin miscompares++; $display("FAIL error_clear: got %b want 0", dram_read_error); end
    strobe(39'h1000, 32);
    end_strobe();
    for (int i = 0; i < 200 && got_data.size() < 3; i++) begin @(posedge clk_pixel); #1; end
    strobe(39'h5000, 10);
    end_strobe();
    wait_idle(low_cyc, to);
    vectors++; if (to) begin miscompares++; $display("FAIL drop_timeout: got busy want idle"); end
    vectors++; if (ar_addr_q.size() != 1) begin miscompares++; $display("FAIL drop_ar_count: got %0d want 1", ar_addr_q.size()); end
    vectors++; if (got_data.size() != 32) begin miscompares++; $display("FAIL drop_beats: got %0d want 32", got_data.size()); end
    vectors++; if (dram_read_error !== 1'b1) begin miscompares++; $display("FAIL drop_error: got %b want 1", dram_read_error); end
  endtask

  task automatic test_len0_reset();
    apply_reset();
    r_delay = 1; gap_en = 1'b0;
    strobe(39'h2000, 0);
    vectors++; if (dram_read_busy !== 1'b1) begin miscompares++; $display("FAIL len0_busy_strobe: got %b want 1", dram_read_busy); end
    end_strobe();
    repeat (10) @(posedge clk_pixel);
    #1;
    vectors++; if (ar_addr_q.size() != 0) begin miscompares++; $display("FAIL len0_ar: got %0d want 0", ar_addr_q.size()); end
    vectors++; if (dram_read_busy !== 1'b0) begin miscompares++; $display("FAIL len0_busy: got %b want 0", dram_read_busy); end
    strobe(39'h1000, 240);
    end_strobe();
    for (int i = 0; i < 500 && got_data.size() < 50; i++) begin @(posedge clk_pixel); #1; end
    vectors++; if (got_data.size() < 50) begin miscompares++; $display("FAIL midburst_reach: got %0d beats want >=50", got_data.size()); end
    strobe(39'h4000, 8);
    end_strobe();
    vectors++; if (dram_read_error !== 1'b1) begin miscompares++; $display("FAIL pre_reset_error: got %b want 1", dram_read_error); end
    dram_reader_reset = 1'b1;
    @(posedge clk_pixel); #1;
    vectors++; if (m_axi_arvalid !== 1'b0 || m_axi_rready !== 1'b0) begin miscompares++; $display("FAIL midreset_axi: got arvalid %b rready %b want 0 0", m_axi_arvalid, m_axi_rready); end
    vectors++; if (dram_read_busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b want 0", dram_read_busy); end
    vectors++; if (dram_read_error !== 1'b0) begin miscompares++; $display("FAIL midreset_error: got %b want 0", dram_read_error); end
    vectors++; if (dram_read_data_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_valid: got %b want 0", dram_read_data_valid); end
    repeat (2) @(posedge clk_pixel);
    #1;
    dram_reader_reset = 1'b0;
    repeat (20) @(posedge clk_pixel);
    #1;
    vectors++; if (m_axi_arvalid !== 1'b0 || dram_read_busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle: got arvalid %b busy %b want 0 0", m_axi_arvalid, dram_read_busy); end
  endtask

`ifdef DRAM_READER_PERF_EN
  task automatic test_perf();
    test_transfer(39'h1F00, 240, 7, 1'b0);
    vectors++; if (perf_burst_count !== 32'd2) begin miscompares++; $display("FAIL perf_bursts: got %0d want 2", perf_burst_count); end
    vectors++; if (perf_max_latency !== 16'd7) begin miscompares++; $display("FAIL perf_latency: got %0d want 7", perf_max_latency); end
  endtask
`endif

  initial begin
    dram_reader_reset = 1'b1;
    dram_read_addr    = '0;
    dram_read_len     = '0;
    dram_read_en      = 1'b0;
    test_reset();
    test_transfer(39'h1000, 240, 1, 1'b0);
    test_transfer(39'h1F00, 240, 1, 1'b0);
    test_transfer(39'h7F_FFFF_FF80, 40, 2, 1'b0);
    test_transfer(39'h0F1B, 255, 1, 1'b1);
    test_transfer(39'h0FF0, 1, 3, 1'b0);
    test_random();
    test_ar_stall();
    test_error();
    test_len0_reset();
`ifdef DRAM_READER_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
